// File: rtl/ps2_scancode_fifo.sv
// Turns raw PS/2 Set-2 bytes into complete key events (E0/F0 prefixes, Pause
// sequence) and queues them in a first-word-fall-through FIFO drained by valid/ready.
module ps2_scancode_fifo #(
  parameter int DEPTH       = 8,
  parameter bit DROP_BREAK  = 1'b0,
  parameter bit FILTER_CTRL = 1'b1
) (
  input  logic                     CLOCK_50,
  input  logic                     resetn,
  input  logic [7:0]               ps2_data,
  input  logic                     ps2_data_en,
  input  logic                     evt_ready,
  input  logic                     clr_overflow,
  output logic                     evt_valid,
  output logic [7:0]               evt_code,
  output logic                     evt_ext,
  output logic                     evt_break,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [7:0]               last_code
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    PREFIX,
    PAUSE
  } state_t;

  state_t     state, state_nxt;
  logic       ext_q, ext_nxt;
  logic       brk_q, brk_nxt;
  logic [2:0] skip_q, skip_nxt;
  logic       emit;
  logic [9:0] emit_entry;
  logic       is_ctrl;

  assign is_ctrl = (ps2_data == 8'hFA) || (ps2_data == 8'hAA) ||
                   (ps2_data == 8'hEE) || (ps2_data == 8'hFE) ||
                   (ps2_data == 8'h00) || (ps2_data == 8'hFF);

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state  <= IDLE;
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      skip_q <= 3'd0;
    end else begin
      state  <= state_nxt;
      ext_q  <= ext_nxt;
      brk_q  <= brk_nxt;
      skip_q <= skip_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ext_nxt    = ext_q;
    brk_nxt    = brk_q;
    skip_nxt   = skip_q;
    emit       = 1'b0;
    emit_entry = {brk_q, ext_q, ps2_data};
    if (ps2_data_en) begin
      unique case (state)
        IDLE: begin
          if (ps2_data == 8'hE0) begin
            ext_nxt   = 1'b1;
            state_nxt = PREFIX;
          end else if (ps2_data == 8'hF0) begin
            brk_nxt   = 1'b1;
            state_nxt = PREFIX;
          end else if (ps2_data == 8'hE1) begin
            skip_nxt  = 3'd7;
            state_nxt = PAUSE;
          end else if (!(FILTER_CTRL && is_ctrl)) begin
            emit       = 1'b1;
            emit_entry = {2'b00, ps2_data};
          end
        end
        PREFIX: begin
          if (ps2_data == 8'hE0) begin
            ext_nxt = 1'b1;
          end else if (ps2_data == 8'hF0) begin
            brk_nxt = 1'b1;
          end else begin
            emit      = 1'b1;
            ext_nxt   = 1'b0;
            brk_nxt   = 1'b0;
            state_nxt = IDLE;
          end
        end
        PAUSE: begin
          // The remaining seven Pause bytes are counted, never inspected.
          if (skip_q <= 3'd1) begin
            emit       = 1'b1;
            emit_entry = {2'b00, 8'hE1};
            skip_nxt   = 3'd0;
            state_nxt  = IDLE;
          end else begin
            skip_nxt = skip_q - 3'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, want_push, push;

  assign full      = (count == (AW+1)'(DEPTH));
  assign pop       = (count != '0) && evt_ready;
  assign want_push = emit && !(DROP_BREAK && emit_entry[9]);
  assign push      = want_push && (!full || pop);

  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      mem[wr_ptr] <= emit_entry;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      last_code <= 8'h00;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear must still be reported.
      if (want_push && !push) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
      if (ps2_data_en) begin
        last_code <= ps2_data;
      end
    end
  end

  assign evt_valid  = (count != '0);
  assign fifo_count = count;
  assign evt_code   = evt_valid ? mem[rd_ptr][7:0] : 8'h00;
  assign evt_ext    = evt_valid ? mem[rd_ptr][8]   : 1'b0;
  assign evt_break  = evt_valid ? mem[rd_ptr][9]   : 1'b0;

endmodule

// File: tb/tb_ps2_scancode_fifo.sv
// Scoreboard bench: a byte-sequence key-event model feeds expected-event queues
// for a default build and a DROP_BREAK build; a negedge monitor checks both.
module tb_ps2_scancode_fifo;

  localparam int DEPTH = 8;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_data_en = 1'b0;
  logic       evt_ready = 1'b0;
  logic       clr_overflow = 1'b0;

  logic       evt_valid, evt_ext, evt_break, overflow;
  logic [7:0] evt_code, last_code;
  logic [3:0] fifo_count;

  logic       evt_valid_d, evt_ext_d, evt_break_d, overflow_d;
  logic [7:0] evt_code_d, last_code_d;
  logic [3:0] fifo_count_d;

  always #5 CLOCK_50 = ~CLOCK_50;

  ps2_scancode_fifo #(.DEPTH(DEPTH), .DROP_BREAK(1'b0), .FILTER_CTRL(1'b1)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .ps2_data(ps2_data), .ps2_data_en(ps2_data_en),
    .evt_ready(evt_ready), .clr_overflow(clr_overflow), .evt_valid(evt_valid),
    .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break),
    .fifo_count(fifo_count), .overflow(overflow), .last_code(last_code)
  );

  ps2_scancode_fifo #(.DEPTH(DEPTH), .DROP_BREAK(1'b1), .FILTER_CTRL(1'b1)) dutDrop (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .ps2_data(ps2_data), .ps2_data_en(ps2_data_en),
    .evt_ready(evt_ready), .clr_overflow(clr_overflow), .evt_valid(evt_valid_d),
    .evt_code(evt_code_d), .evt_ext(evt_ext_d), .evt_break(evt_break_d),
    .fifo_count(fifo_count_d), .overflow(overflow_d), .last_code(last_code_d)
  );

  int assertCount = 0;
  int failCount = 0;

  logic [9:0] expQ[$];
  logic [9:0] expQDrop[$];
  logic [7:0] pend[$];
  logic [7:0] seq[$];

  int         modelCount = 0, modelCountDrop = 0;
  logic       modelOvf = 1'b0, modelOvfDrop = 1'b0;
  logic [7:0] modelLast = 8'h00;
  int         visCount = 0, visCountDrop = 0;
  logic       visOvf = 1'b0, visOvfDrop = 1'b0;
  logic [7:0] visLast = 8'h00;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic isCtrl(input logic [7:0] b);
    return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  // Key events are judged from the whole buffered byte run, not from a state machine.
  task automatic decodeByte(input logic [7:0] b, output logic valid, output logic [9:0] ev);
    logic ext, brk;
    valid = 1'b0;
    ev = '0;
    if (pend.size() > 0 && pend[0] == 8'hE1) begin
      pend.push_back(b);
      if (pend.size() == 8) begin
        valid = 1'b1;
        ev = {2'b00, 8'hE1};
        pend.delete();
      end
    end else if (pend.size() == 0 && b == 8'hE1) begin
      pend.push_back(b);
    end else if (b == 8'hE0 || b == 8'hF0) begin
      pend.push_back(b);
    end else if (!(pend.size() == 0 && isCtrl(b))) begin
      ext = 1'b0;
      brk = 1'b0;
      foreach (pend[k]) begin
        if (pend[k] == 8'hE0) ext = 1'b1;
        if (pend[k] == 8'hF0) brk = 1'b1;
      end
      valid = 1'b1;
      ev = {brk, ext, b};
      pend.delete();
    end
  endtask

  task automatic modelFifo(input int cnt, input logic ovf, input logic rdy, input logic clr,
                           input logic want, output int nCnt, output logic nOvf,
                           output logic doPush);
    logic doPop;
    doPop  = (cnt > 0) && rdy;
    doPush = want && ((cnt < DEPTH) || doPop);
    nCnt   = cnt + (doPush ? 1 : 0) - (doPop ? 1 : 0);
    nOvf   = (want && !doPush) ? 1'b1 : (clr ? 1'b0 : ovf);
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic [7:0] b,
                               input logic rdy, input logic clr);
    logic       rdyEff, evValid, doPush;
    logic [9:0] ev;
    int         nCnt;
    logic       nOvf;
    @(posedge CLOCK_50);
    #1;
    rdyEff       = rst ? 1'b0 : rdy;
    resetn       = !rst;
    ps2_data_en  = en;
    ps2_data     = b;
    evt_ready    = rdyEff;
    clr_overflow = clr;
    visCount     = modelCount;
    visOvf       = modelOvf;
    visLast      = modelLast;
    visCountDrop = modelCountDrop;
    visOvfDrop   = modelOvfDrop;
    if (rst) begin
      modelCount = 0;
      modelOvf = 1'b0;
      modelLast = 8'h00;
      modelCountDrop = 0;
      modelOvfDrop = 1'b0;
      expQ.delete();
      expQDrop.delete();
      pend.delete();
    end else begin
      evValid = 1'b0;
      ev = '0;
      if (en) begin
        decodeByte(b, evValid, ev);
        modelLast = b;
      end
      modelFifo(modelCount, modelOvf, rdyEff, clr, evValid, nCnt, nOvf, doPush);
      modelCount = nCnt;
      modelOvf = nOvf;
      if (doPush) expQ.push_back(ev);
      modelFifo(modelCountDrop, modelOvfDrop, rdyEff, clr, evValid && !ev[9], nCnt, nOvf, doPush);
      modelCountDrop = nCnt;
      modelOvfDrop = nOvf;
      if (doPush) expQDrop.push_back(ev);
    end
  endtask

  task automatic sendSeq(input logic rdy);
    foreach (seq[k]) applyStimulus(1'b0, 1'b1, seq[k], rdy, 1'b0);
  endtask

  task automatic idleCycles(input int n, input logic rdy);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 8'h00, rdy, 1'b0);
  endtask

  // Monitor: inputs change just after posedge, so negedge sees a settled cycle.
  always @(negedge CLOCK_50) begin
    logic [9:0] e;
    checkOutput("count", 32'(fifo_count), 32'(visCount));
    checkOutput("valid", 32'(evt_valid), 32'(visCount != 0));
    checkOutput("overflow", 32'(overflow), 32'(visOvf));
    checkOutput("last_code", 32'(last_code), 32'(visLast));
    checkOutput("countDrop", 32'(fifo_count_d), 32'(visCountDrop));
    checkOutput("overflowDrop", 32'(overflow_d), 32'(visOvfDrop));
    if (!evt_valid) begin
      checkOutput("emptyHead", 32'({evt_break, evt_ext, evt_code}), 32'h0);
    end else if (evt_ready) begin
      assertCount++;
      if (expQ.size() == 0) begin
        failCount++;
        $display("[TB] FAIL head: got %0h, expected no event", {evt_break, evt_ext, evt_code});
      end else begin
        e = expQ.pop_front();
        assertCount--;
        checkOutput("head", 32'({evt_break, evt_ext, evt_code}), 32'(e));
      end
    end
    if (evt_valid_d && evt_ready) begin
      assertCount++;
      if (expQDrop.size() == 0) begin
        failCount++;
        $display("[TB] FAIL headDrop: got %0h, expected no event", {evt_break_d, evt_ext_d, evt_code_d});
      end else begin
        e = expQDrop.pop_front();
        assertCount--;
        checkOutput("headDrop", 32'({evt_break_d, evt_ext_d, evt_code_d}), 32'(e));
      end
    end
  end

  logic [7:0] ctrlCodes [6] = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

  initial begin
    logic [7:0] b;
    int r;
    logic en, rdy, clr, rst;

    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    seq = '{8'h1C, 8'hF0, 8'h1C};
    sendSeq(1'b0);
    idleCycles(2, 1'b0);
    idleCycles(4, 1'b1);

    seq = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    sendSeq(1'b0);
    idleCycles(2, 1'b0);
    idleCycles(4, 1'b1);

    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h29};
    sendSeq(1'b0);
    idleCycles(2, 1'b0);
    idleCycles(4, 1'b1);

    seq = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h3B};
    sendSeq(1'b0);
    idleCycles(2, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    idleCycles(1, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h4B, 1'b1, 1'b0);
    idleCycles(2, 1'b0);
    idleCycles(12, 1'b1);

    seq = '{8'hFA, 8'hAA, 8'hE0};
    sendSeq(1'b1);
    applyStimulus(1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    seq = '{8'h1C};
    sendSeq(1'b0);
    idleCycles(2, 1'b0);
    idleCycles(3, 1'b1);

    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 15)      b = 8'hE0;
      else if (r < 28) b = 8'hF0;
      else if (r < 33) b = 8'hE1;
      else if (r < 40) b = ctrlCodes[$urandom_range(0, 5)];
      else             b = 8'($urandom_range(0, 255));
      en  = ($urandom_range(0, 3) != 0);
      rdy = ((i % 100) < 40) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 1);
      clr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 299) == 0);
      applyStimulus(rst, en, b, rdy, clr);
    end
    idleCycles(20, 1'b1);
    @(posedge CLOCK_50);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
